bfly_pair_addsub: RTL and testbench

Radix-2 butterfly add/subtract stage that directly consumes the registered twiddle-multiplier output vectors. Incoming N-lane complex vectors arrive in pairs (A, B). The block holds A, then on B emits A+B followed by A−B as two consecutive N-lane output vectors. It performs no backpressure and sustains one input vector per cycle.

---
 rtl/bfly_pair_addsub_if.sv | 27 ++
 rtl/bfly_pair_addsub.sv | 144 ++++++++++++++
 tb/tb_bfly_pair_addsub.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bfly_pair_addsub_if.sv
// Lane-packed input/output bundle for the radix-2 butterfly add/sub stage.
// Lane i occupies bits [i*W +: W] of each real/imag bus.
interface bfly_pair_addsub_if #(
   parameter int IN_W  = 10,
   parameter int OUT_W = IN_W + 1,
   parameter int N     = 16
);
   logic                 din_valid;
   logic                 din_sof;
   logic [N*IN_W-1:0]    din_re;
   logic [N*IN_W-1:0]    din_im;
   logic                 dout_valid;
   logic                 dout_sel;
   logic [N*OUT_W-1:0]   dout_re;
   logic [N*OUT_W-1:0]   dout_im;
   logic                 err_orphan;

   modport master (
      output din_valid, din_sof, din_re, din_im,
      input  dout_valid, dout_sel, dout_re, dout_im, err_orphan
   );

   modport slave (
      input  din_valid, din_sof, din_re, din_im,
      output dout_valid, dout_sel, dout_re, dout_im, err_orphan
   );
endinterface

// File: rtl/bfly_pair_addsub.sv
// Radix-2 butterfly add/subtract: holds vector A, emits A+B on B, then A-B the
// following cycle. Full-precision results, no backpressure.
module bfly_pair_addsub #(
   parameter int IN_W  = 10,
   parameter int OUT_W = IN_W + 1,
   parameter int N     = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   bfly_pair_addsub_if.slave    io
);

   typedef enum logic {S_A = 1'b0, S_B = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [N*IN_W-1:0]    hold_re_q, hold_re_d;
   logic [N*IN_W-1:0]    hold_im_q, hold_im_d;
   logic [N*OUT_W-1:0]   diff_re_q, diff_re_d;
   logic [N*OUT_W-1:0]   diff_im_q, diff_im_d;
   logic                 diff_pend_q, diff_pend_d;
   logic                 dout_valid_q, dout_valid_d;
   logic                 dout_sel_q, dout_sel_d;
   logic [N*OUT_W-1:0]   dout_re_q, dout_re_d;
   logic [N*OUT_W-1:0]   dout_im_q, dout_im_d;
   logic                 err_q, err_d;
   logic                 take_b;

   logic [N*OUT_W-1:0]   sum_re, sum_im, dif_re, dif_im;

   function automatic logic signed [OUT_W-1:0] sext(input logic signed [IN_W-1:0] x);
      return {{(OUT_W-IN_W){x[IN_W-1]}}, x};
   endfunction

   function automatic logic signed [OUT_W-1:0] lane_add(input logic signed [IN_W-1:0] a,
                                                         input logic signed [IN_W-1:0] b);
      return sext(a) + sext(b);
   endfunction

   function automatic logic signed [OUT_W-1:0] lane_sub(input logic signed [IN_W-1:0] a,
                                                         input logic signed [IN_W-1:0] b);
      return sext(a) - sext(b);
   endfunction

   // Stage p0: per-lane butterfly of the held A against the incoming B
   for (genvar i = 0; i < N; i++) begin : g_lane
      assign sum_re[i*OUT_W +: OUT_W] = lane_add(hold_re_q[i*IN_W +: IN_W], io.din_re[i*IN_W +: IN_W]);
      assign sum_im[i*OUT_W +: OUT_W] = lane_add(hold_im_q[i*IN_W +: IN_W], io.din_im[i*IN_W +: IN_W]);
      assign dif_re[i*OUT_W +: OUT_W] = lane_sub(hold_re_q[i*IN_W +: IN_W], io.din_re[i*IN_W +: IN_W]);
      assign dif_im[i*OUT_W +: OUT_W] = lane_sub(hold_im_q[i*IN_W +: IN_W], io.din_im[i*IN_W +: IN_W]);
   end

   always_comb begin
      state_d   = state_q;
      hold_re_d = hold_re_q;
      hold_im_d = hold_im_q;
      err_d     = 1'b0;
      take_b    = 1'b0;
      case (state_q)
         S_A: begin
            if (io.din_valid) begin
               hold_re_d = io.din_re;
               hold_im_d = io.din_im;
               state_d   = S_B;
            end
         end
         S_B: begin
            if (io.din_valid) begin
               if (io.din_sof) begin
                  // A fresh start-of-frame replaces the stranded A
                  hold_re_d = io.din_re;
                  hold_im_d = io.din_im;
                  err_d     = 1'b1;
               end else begin
                  take_b  = 1'b1;
                  state_d = S_A;
               end
            end
         end
         default: state_d = S_A;
      endcase
   end

   // Output select: a new sum always wins; the pending diff drains the cycle after
   always_comb begin
      dout_valid_d = 1'b0;
      dout_sel_d   = dout_sel_q;
      dout_re_d    = dout_re_q;
      dout_im_d    = dout_im_q;
      diff_pend_d  = diff_pend_q;
      diff_re_d    = diff_re_q;
      diff_im_d    = diff_im_q;
      if (take_b) begin
         dout_valid_d = 1'b1;
         dout_sel_d   = 1'b0;
         dout_re_d    = sum_re;
         dout_im_d    = sum_im;
         diff_re_d    = dif_re;
         diff_im_d    = dif_im;
         diff_pend_d  = 1'b1;
      end else if (diff_pend_q) begin
         dout_valid_d = 1'b1;
         dout_sel_d   = 1'b1;
         dout_re_d    = diff_re_q;
         dout_im_d    = diff_im_q;
         diff_pend_d  = 1'b0;
      end
   end

   // Stage p1: registered outputs and buffers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_A;
         hold_re_q    <= '0;
         hold_im_q    <= '0;
         diff_re_q    <= '0;
         diff_im_q    <= '0;
         diff_pend_q  <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_sel_q   <= 1'b0;
         dout_re_q    <= '0;
         dout_im_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_re_q    <= hold_re_d;
         hold_im_q    <= hold_im_d;
         diff_re_q    <= diff_re_d;
         diff_im_q    <= diff_im_d;
         diff_pend_q  <= diff_pend_d;
         dout_valid_q <= dout_valid_d;
         dout_sel_q   <= dout_sel_d;
         dout_re_q    <= dout_re_d;
         dout_im_q    <= dout_im_d;
         err_q        <= err_d;
      end
   end

   assign io.dout_valid = dout_valid_q;
   assign io.dout_sel   = dout_sel_q;
   assign io.dout_re    = dout_re_q;
   assign io.dout_im    = dout_im_q;
   assign io.err_orphan = err_q;

endmodule

// File: tb/tb_bfly_pair_addsub.sv
// Directed-vector bench for bfly_pair_addsub: pairs, extremes, streaming,
// gaps, orphan resync and asynchronous reset.
module tb_bfly_pair_addsub;

   localparam int IN_W  = 10;
   localparam int OUT_W = 11;
   localparam int N     = 16;
   localparam int IW    = N * IN_W;
   localparam int OW    = N * OUT_W;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   bfly_pair_addsub_if #(.IN_W(IN_W), .OUT_W(OUT_W), .N(N)) bus ();

   bfly_pair_addsub #(.IN_W(IN_W), .OUT_W(OUT_W), .N(N)) dut (
      .clk  (clk),
      .rstn (rstn),
      .io   (bus)
   );

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] fin(input int v);
      logic [IW-1:0] r;
      for (int i = 0; i < N; i++) r[i*IN_W +: IN_W] = IN_W'(v);
      return r;
   endfunction

   function automatic logic [OW-1:0] fout(input int v);
      logic [OW-1:0] r;
      for (int i = 0; i < N; i++) r[i*OUT_W +: OUT_W] = OUT_W'(v);
      return r;
   endfunction

   function automatic logic [IW-1:0] ramp(input int k, input int s);
      logic [IW-1:0] r;
      for (int i = 0; i < N; i++) r[i*IN_W +: IN_W] = IN_W'(s * (k*N + i));
      return r;
   endfunction

   // Golden per-lane model using integer arithmetic
   function automatic logic [OW-1:0] model(input logic [IW-1:0] a, input logic [IW-1:0] b, input bit sub);
      logic [OW-1:0] r;
      int x, y;
      for (int i = 0; i < N; i++) begin
         x = $signed(a[i*IN_W +: IN_W]);
         y = $signed(b[i*IN_W +: IN_W]);
         r[i*OUT_W +: OUT_W] = OUT_W'(sub ? x - y : x + y);
      end
      return r;
   endfunction

   task automatic drive(input bit v, input bit sof, input logic [IW-1:0] re, input logic [IW-1:0] im);
      @(negedge clk);
      bus.din_valid = v;
      bus.din_sof   = sof;
      bus.din_re    = re;
      bus.din_im    = im;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0);
   endtask

   task automatic chk_out(input string tag, input bit v, input bit sel, input logic [OW-1:0] re,
                          input logic [OW-1:0] im);
      chk({tag, "_valid"}, 256'(bus.dout_valid), 256'(v));
      chk({tag, "_sel"},   256'(bus.dout_sel),   256'(sel));
      chk({tag, "_re"},    256'(bus.dout_re),    256'(re));
      chk({tag, "_im"},    256'(bus.dout_im),    256'(im));
   endtask

   logic [IW-1:0] sv_re [8];
   logic [IW-1:0] sv_im [8];

   initial begin
      bus.din_valid = 1'b0;
      bus.din_sof   = 1'b0;
      bus.din_re    = '0;
      bus.din_im    = '0;

      // Reset state
      @(negedge clk);
      chk_out("rst", 1'b0, 1'b0, '0, '0);
      chk("rst_err", 256'(bus.err_orphan), 256'(0));
      @(negedge clk);
      rstn = 1'b1;

      // Single pair
      drive(1'b1, 1'b0, fin(100), fin(-50));
      drive(1'b1, 1'b0, fin(30),  fin(20));
      chk("p1_pre_valid", 256'(bus.dout_valid), 256'(0));
      idle();
      chk_out("p1_sum", 1'b1, 1'b0, fout(130), fout(-30));
      idle();
      chk_out("p1_diff", 1'b1, 1'b1, fout(70), fout(-70));
      idle();
      chk("p1_post_valid", 256'(bus.dout_valid), 256'(0));

      // Extremes
      drive(1'b1, 1'b0, fin(-512), fin(-512));
      drive(1'b1, 1'b0, fin(-512), fin(-512));
      idle();
      chk_out("ext_sum_min", 1'b1, 1'b0, fout(-1024), fout(-1024));
      idle();
      chk_out("ext_diff_zero", 1'b1, 1'b1, fout(0), fout(0));
      drive(1'b1, 1'b0, fin(511), fin(511));
      drive(1'b1, 1'b0, fin(-512), fin(-512));
      idle();
      chk_out("ext_sum_m1", 1'b1, 1'b0, fout(-1), fout(-1));
      idle();
      chk_out("ext_diff_max", 1'b1, 1'b1, fout(1023), fout(1023));

      // Back-to-back stream of 8 vectors
      for (int k = 0; k < 8; k++) begin
         sv_re[k] = ramp(k, 1);
         sv_im[k] = ramp(k, -1);
      end
      for (int c = 0; c < 10; c++) begin
         if (c < 8) drive(1'b1, 1'b0, sv_re[c], sv_im[c]);
         else       idle();
         if (c == 1) chk("str_first_valid", 256'(bus.dout_valid), 256'(0));
         if (c >= 2) begin
            int p;
            bit s;
            p = (c - 2) / 2;
            s = bit'((c - 2) % 2);
            chk_out($sformatf("str_c%0d", c), 1'b1, s,
                    model(sv_re[2*p], sv_re[2*p+1], s), model(sv_im[2*p], sv_im[2*p+1], s));
         end
      end

      // Gapped pair
      drive(1'b1, 1'b0, fin(5), fin(-6));
      for (int g = 0; g < 5; g++) begin
         idle();
         chk($sformatf("gap%0d_valid", g), 256'(bus.dout_valid), 256'(0));
      end
      drive(1'b1, 1'b0, fin(-7), fin(8));
      chk("gap_b_valid", 256'(bus.dout_valid), 256'(0));
      idle();
      chk_out("gap_sum", 1'b1, 1'b0, fout(-2), fout(2));
      idle();
      chk_out("gap_diff", 1'b1, 1'b1, fout(12), fout(-14));

      // Orphan resync
      drive(1'b1, 1'b0, fin(7), fin(7));
      drive(1'b1, 1'b1, fin(200), fin(-100));
      chk("orph_err_early", 256'(bus.err_orphan), 256'(0));
      drive(1'b1, 1'b0, fin(-3), fin(50));
      chk("orph_err_pulse", 256'(bus.err_orphan), 256'(1));
      chk("orph_no_out", 256'(bus.dout_valid), 256'(0));
      idle();
      chk("orph_err_clear", 256'(bus.err_orphan), 256'(0));
      chk_out("orph_sum", 1'b1, 1'b0, fout(197), fout(-50));
      idle();
      chk_out("orph_diff", 1'b1, 1'b1, fout(203), fout(-150));
      idle();
      chk("orph_end_valid", 256'(bus.dout_valid), 256'(0));

      // Asynchronous reset mid-stream with an A held
      drive(1'b1, 1'b0, fin(1), fin(2));
      drive(1'b1, 1'b0, fin(3), fin(4));
      drive(1'b1, 1'b0, fin(50), fin(50));
      chk_out("rst2_pre_sum", 1'b1, 1'b0, fout(4), fout(6));
      #1 rstn = 1'b0;
      #1;
      chk_out("rst2_async", 1'b0, 1'b0, '0, '0);
      chk("rst2_err", 256'(bus.err_orphan), 256'(0));
      idle();
      idle();
      rstn = 1'b1;
      drive(1'b1, 1'b0, fin(10), fin(10));
      chk("rst2_no_diff", 256'(bus.dout_valid), 256'(0));
      drive(1'b1, 1'b0, fin(20), fin(-20));
      chk("rst2_x_is_a", 256'(bus.dout_valid), 256'(0));
      idle();
      chk_out("rst2_sum", 1'b1, 1'b0, fout(30), fout(-10));
      idle();
      chk_out("rst2_diff", 1'b1, 1'b1, fout(-10), fout(30));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
